// File: rtl/sram_access_ctrl_if.sv
// ============================================================================
// Module      : sram_access_ctrl_if
// Description : Pipeline-side request/response bundle for sram_access_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface sram_access_ctrl_if;
    logic        wr_en;
    logic        rd_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;

    // Pipeline (EX/MEM side) issues requests; the controller answers.
    modport master (
        output wr_en, rd_en, address, write_data,
        input  read_data, ready
    );

    modport slave (
        input  wr_en, rd_en, address, write_data,
        output read_data, ready
    );
endinterface

`default_nettype wire

// File: rtl/sram_access_ctrl.sv
// ============================================================================
// Module      : sram_access_ctrl
// Description : Splits 32-bit data accesses into two wait-stated 16-bit SRAM
//               phases and stalls the pipeline until the access completes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_access_ctrl #(
    parameter int WAIT_CYCLES = 2,
    parameter int BASE_ADDR   = 1024,
    parameter int SRAM_AW     = 18
) (
    input  wire logic               clk,
    input  wire logic               rst,
    sram_access_ctrl_if.slave       bus,
    output logic [SRAM_AW-1:0]      sram_addr,
    output logic [15:0]             sram_dq_out,
    input  wire logic [15:0]        sram_dq_in,
    output logic                    sram_dq_oe,
    output logic                    sram_we_n
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

    state_t             state;
    state_t             state_next;
    logic [3:0]         cnt;
    logic               op_write;
    logic [SRAM_AW-2:0] word;
    logic [31:0]        wdata;
    logic [31:0]        rdata;

    logic               start;
    logic               cap_lo;
    logic               cap_hi;
    logic               phase_end;
    logic               in_phase;
    logic               ready_int;
    logic [31:0]        offset;
    logic               unused_offset_bits;

    // Byte offset from the SRAM window; only whole-word bits reach the SRAM.
    assign offset             = bus.address - 32'(BASE_ADDR);
    assign unused_offset_bits = ^{offset[31:SRAM_AW+1], offset[1:0]};

    assign in_phase  = (state == LOW) || (state == HIGH);
    assign phase_end = in_phase && (cnt == LAST_CNT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        start      = 1'b0;
        cap_lo     = 1'b0;
        cap_hi     = 1'b0;
        ready_int  = 1'b0;
        case (state)
            IDLE: begin
                ready_int = !(bus.wr_en || bus.rd_en);
                if (bus.wr_en || bus.rd_en) begin
                    start      = 1'b1;
                    state_next = LOW;
                end
            end
            LOW: begin
                if (cnt == LAST_CNT) begin
                    cap_lo     = !op_write;
                    state_next = HIGH;
                end
            end
            HIGH: begin
                if (cnt == LAST_CNT) begin
                    cap_hi     = !op_write;
                    state_next = DONE;
                end
            end
            DONE: begin
                // Requests still held here are deliberately not restarted.
                ready_int  = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt      <= 4'd0;
            op_write <= 1'b0;
            word     <= '0;
            wdata    <= 32'd0;
            rdata    <= 32'd0;
        end else begin
            if (start) begin
                cnt      <= 4'd0;
                op_write <= bus.wr_en;
                word     <= offset[SRAM_AW:2];
                wdata    <= bus.write_data;
            end else if (phase_end) begin
                cnt <= 4'd0;
            end else if (in_phase) begin
                cnt <= cnt + 4'd1;
            end

            if (cap_lo) begin
                rdata[15:0] <= sram_dq_in;
            end
            if (cap_hi) begin
                rdata[31:16] <= sram_dq_in;
            end
        end
    end

    // SRAM strobes decode straight from state so an async reset releases the bus at once.
    always_comb begin
        sram_addr   = {word, (state == HIGH)};
        sram_dq_out = 16'd0;
        if (state == LOW) begin
            sram_dq_out = wdata[15:0];
        end else if (state == HIGH) begin
            sram_dq_out = wdata[31:16];
        end
    end

    assign sram_dq_oe    = op_write && in_phase;
    assign sram_we_n     = !(op_write && in_phase);
    assign bus.read_data = rdata;
    assign bus.ready     = ready_int;

endmodule

`default_nettype wire
